semaforo_timebase: RTL and testbench

//  Timebase stage directly upstream of the traffic-light sequencer. Divides the board

---
 rtl/semaforo_timebase.sv | 101 ++++++++++
 tb/tb_semaforo_timebase.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/semaforo_timebase.sv
// Timebase for the traffic-light sequencer: slow step clock (clk_out) plus a one-cycle tick.
// Optional single-step pushbutton support is compiled in with SEMAFORO_STEP_EN.
module semaforo_timebase #(
    parameter int DIV_SLOW = 50_000_000,
    parameter int DIV_FAST = 5_000_000,
    parameter int CW       = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic fast,
`ifdef SEMAFORO_STEP_EN
    input  logic step,
`endif
    output logic clk_out,
    output logic tick
);

    localparam logic [CW:0] N_SLOW = (CW+1)'(DIV_SLOW);
    localparam logic [CW:0] N_FAST = (CW+1)'(DIV_FAST);
    localparam logic [CW:0] ONE    = (CW+1)'(1);

    logic          run_m, run_s;
    logic          fast_m, fast_s;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] cnt_nx;
    logic [CW:0]   n;
    logic [CW:0]   half;
    logic          term;
    logic          clk_out_nx;
    logic          tick_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_m  <= 1'b0;
            run_s  <= 1'b0;
            fast_m <= 1'b0;
            fast_s <= 1'b0;
        end else begin
            run_m  <= run;
            run_s  <= run_m;
            fast_m <= fast;
            fast_s <= fast_m;
        end
    end

`ifdef SEMAFORO_STEP_EN
    logic step_m, step_s, step_d;
    logic step_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_m <= 1'b0;
            step_s <= 1'b0;
            step_d <= 1'b0;
        end else begin
            step_m <= step;
            step_s <= step_m;
            step_d <= step_s;
        end
    end

    assign step_req = step_s & ~step_d;
`endif

    // The >= compare lets a count left beyond a freshly shortened period wrap at once.
    always_comb begin
        n          = fast_s ? N_FAST : N_SLOW;
        half       = n >> 1;
        term       = ({1'b0, cnt} >= (n - ONE));
        cnt_inc    = term ? '0 : cnt + CW'(1);
        cnt_nx     = '0;
        clk_out_nx = 1'b0;
        tick_nx    = 1'b0;
        if (run_s) begin
            cnt_nx     = cnt_inc;
            tick_nx    = term;
            clk_out_nx = ({1'b0, cnt_inc} >= half);
        end
`ifdef SEMAFORO_STEP_EN
        else if (step_req) begin
            tick_nx    = 1'b1;
            clk_out_nx = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            cnt     <= cnt_nx;
            clk_out <= clk_out_nx;
            tick    <= tick_nx;
        end
    end

endmodule

// File: tb/tb_semaforo_timebase.sv
// Directed bench for semaforo_timebase with DIV_SLOW=8, DIV_FAST=4, CW=4.
// Step-button sequences run only when SEMAFORO_STEP_EN is defined.
`timescale 1ns/1ps
module tb_semaforo_timebase;

    localparam int DS  = 8;
    localparam int DF  = 4;
    localparam int CWT = 4;

    logic clk = 1'b0;
    logic rst;
    logic run;
    logic fast;
`ifdef SEMAFORO_STEP_EN
    logic step;
`endif
    logic clk_out;
    logic tick;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       r;
        logic       f;
        logic [3:0] ecnt;
        logic       eclk;
        logic       etick;
    } vec_t;

    vec_t vecs[$];

    semaforo_timebase #(
        .DIV_SLOW(DS),
        .DIV_FAST(DF),
        .CW(CWT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .run(run),
        .fast(fast),
`ifdef SEMAFORO_STEP_EN
        .step(step),
`endif
        .clk_out(clk_out),
        .tick(tick)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic f, input int c,
                                input logic co, input logic t);
        vec_t v;
        v.r     = r;
        v.f     = f;
        v.ecnt  = 4'(c);
        v.eclk  = co;
        v.etick = t;
        vecs.push_back(v);
    endfunction

    // Drive inputs just after an edge, then move to 1ns past the next edge.
    task automatic applyStimulus(input logic r, input logic f);
        run  = r;
        fast = f;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int idx, input logic [3:0] ecnt,
                               input logic eclk, input logic etick);
        checks++;
        if (dut.cnt !== ecnt || clk_out !== eclk || tick !== etick) begin
            failures++;
            $display("[TB] FAIL %s[%0d]: got cnt=%0d clk_out=%b tick=%b, expected cnt=%0d clk_out=%b tick=%b",
                     name, idx, dut.cnt, clk_out, tick, ecnt, eclk, etick);
        end
    endtask

    initial begin
        logic [3:0] post_cnt [6];
        logic [3:0] res_cnt [10];
        post_cnt = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        res_cnt  = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0};

        // Slow rate from reset release: two sync cycles, then 0000_1111.
        add(1,0,0,0,0); add(1,0,0,0,0); add(1,0,1,0,0); add(1,0,2,0,0);
        add(1,0,3,0,0); add(1,0,4,1,0); add(1,0,5,1,0); add(1,0,6,1,0);
        add(1,0,7,1,0); add(1,0,0,0,1); add(1,0,1,0,0); add(1,0,2,0,0);
        add(1,0,3,0,0); add(1,0,4,1,0); add(1,0,5,1,0); add(1,0,6,1,0);
        add(1,0,7,1,0); add(1,0,0,0,1);
        // fast=1: takes effect two edges later, then 0011 cadence.
        add(1,1,1,0,0); add(1,1,2,0,0); add(1,1,3,1,0); add(1,1,0,0,1);
        add(1,1,1,0,0); add(1,1,2,1,0); add(1,1,3,1,0); add(1,1,0,0,1);
        add(1,1,1,0,0); add(1,1,2,1,0); add(1,1,3,1,0); add(1,1,0,0,1);
        // fast back to 0 so it lands while cnt=2: counting runs on to 7.
        add(1,0,1,0,0); add(1,0,2,1,0); add(1,0,3,0,0); add(1,0,4,1,0);
        add(1,0,5,1,0); add(1,0,6,1,0); add(1,0,7,1,0); add(1,0,0,0,1);
        add(1,0,1,0,0); add(1,0,2,0,0); add(1,0,3,0,0); add(1,0,4,1,0);
        add(1,0,5,1,0); add(1,0,6,1,0); add(1,0,7,1,0); add(1,0,0,0,1);
        add(1,0,1,0,0); add(1,0,2,0,0); add(1,0,3,0,0); add(1,0,4,1,0);
        // fast=1 landing while cnt=6: immediate wrap, then 4-cycle periods.
        add(1,1,5,1,0); add(1,1,6,1,0); add(1,1,0,0,1); add(1,1,1,0,0);
        add(1,1,2,1,0); add(1,1,3,1,0); add(1,1,0,0,1); add(1,1,1,0,0);
        add(1,1,2,1,0); add(1,1,3,1,0); add(1,1,0,0,1); add(1,1,1,0,0);
        // run=0 while clk_out=1, then 20 frozen cycles.
        add(0,1,2,1,0); add(0,1,3,1,0);
        for (int i = 0; i < 5; i++)  add(0,1,0,0,0);
        for (int i = 0; i < 15; i++) add(0,0,0,0,0);
        // Resume at slow rate: first rise 6 edges after run is set.
        add(1,0,0,0,0); add(1,0,0,0,0); add(1,0,1,0,0); add(1,0,2,0,0);
        add(1,0,3,0,0); add(1,0,4,1,0); add(1,0,5,1,0); add(1,0,6,1,0);
        add(1,0,7,1,0); add(1,0,0,0,1);

        rst  = 1'b1;
        run  = 1'b1;
        fast = 1'b0;
`ifdef SEMAFORO_STEP_EN
        step = 1'b0;
`endif
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("in_reset", i, 4'd0, 1'b0, 1'b0);
        end
        rst = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].r, vecs[i].f);
            checkOutput("vec", i, vecs[i].ecnt, vecs[i].eclk, vecs[i].etick);
        end

        // Run into the high half, then reset asynchronously mid-period.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("pre_rst", i, 4'(i + 1), (i >= 3), 1'b0);
        end
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_rst", 0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("rst_held", i, 4'd0, 1'b0, 1'b0);
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("post_rst", i, post_cnt[i], (i == 5), 1'b0);
        end

`ifdef SEMAFORO_STEP_EN
        applyStimulus(1'b0, 1'b0);
        checkOutput("to_hold", 0, 4'd5, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("to_hold", 1, 4'd6, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("to_hold", 2, 4'd0, 1'b0, 1'b0);
        // Held button in hold: one single-cycle pulse, two sync cycles after the press.
        step = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("step_hold", i, 4'd0, (i == 2), (i == 2));
        end
        step = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("step_release", i, 4'd0, 1'b0, 1'b0);
        end
        // Press together with run: ignored, normal resume cadence.
        step = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("step_run", i, res_cnt[i], (i >= 5 && i <= 8), (i == 9));
        end
        step = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
